// File: rtl/sub_defs_pkg.sv
// rtl/sub_defs_pkg.sv - shared definitions for the sequential subtractor
// Purpose: state encodings and datapath width shared by the subtractor and
//          the execute-stage sequencing that drives it.
// Ports:   none (package).
package sub_defs;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    SUB_IDLE = 2'd0,
    SUB_BUSY = 2'd1,
    SUB_DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - one W-bit slice of the chunked subtractor datapath
// Purpose: combinational ripple slice computing {cout, s} = a + b_n + cin.
//          The caller supplies the already-inverted subtrahend chunk, so with
//          cin=1 on the first chunk the slice chain forms a - b.
// Ports:
//   a    in  W  minuend chunk
//   b_n  in  W  inverted subtrahend chunk
//   cin  in  1  carry from the previous chunk (1 for the first chunk)
//   s    out W  sum chunk
//   cout out 1  carry into the next chunk
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_n,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Gate-level full-adder chain (propagate/generate form), evaluated bit by
  // bit in one process so the carry chain stays a single combinational path.
  always_comb begin
    logic c;
    logic p;
    logic g;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      p    = a[i] ^ b_n[i];
      g    = a[i] & b_n[i];
      s[i] = p ^ c;
      c    = g | (p & c);
    end
    cout = c;
  end

endmodule

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - multi-cycle 64-bit subtractor, CHUNK_W bits per cycle
// Purpose: Y = A - B computed LSB chunk first as A + ~B + 1 with a registered
//          carry between chunks. Valid/ready handshake on input and output;
//          holds one operation at a time (IDLE -> BUSY -> DONE).
// Optional feature: macro SUB_FLAGS_EN adds zf/sf/of flag outputs.
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   operands valid
//   in_ready  out  1   operands can be accepted (IDLE only)
//   a         in   64  minuend, sampled on accept
//   b         in   64  subtrahend, sampled on accept
//   out_valid out  1   result valid (DONE only)
//   out_ready in   1   consumer takes result
//   y         out  64  A - B modulo 2^64
//   borrow    out  1   1 when unsigned A < B
//   zf,sf,of  out  1   zero/sign/signed-overflow flags (SUB_FLAGS_EN only)
module seq_subtractor
  import sub_defs::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
`ifdef SUB_FLAGS_EN
  output logic              zf,
  output logic              sf,
  output logic              of,
`endif
  output logic              borrow
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  // A single-chunk build still needs a 1-bit index register.
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  sub_state_e        state_q;
  sub_state_e        state_nxt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] y_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic              borrow_q;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b_n;
  logic [CHUNK_W-1:0] chunk_s;
  logic               chunk_cout;
  logic               last_chunk;
  logic               accept;
  logic               consume;

  assign in_ready   = (state_q == SUB_IDLE);
  assign out_valid  = (state_q == SUB_DONE);
  assign accept     = in_ready & in_valid;
  assign consume    = out_valid & out_ready;
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  assign chunk_a    = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
  assign chunk_b_n  = ~b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

  sub_chunk #(
    .W (CHUNK_W)
  ) u_chunk (
    .a    (chunk_a),
    .b_n  (chunk_b_n),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // Result with the current chunk merged in; flags on DONE entry are derived
  // from this so they match the y value that becomes visible.
  always_comb begin
    y_nxt = y_q;
    y_nxt[int'(idx_q) * CHUNK_W +: CHUNK_W] = chunk_s;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      SUB_IDLE: if (in_valid)   state_nxt = SUB_BUSY;
      SUB_BUSY: if (last_chunk) state_nxt = SUB_DONE;
      SUB_DONE: if (out_ready)  state_nxt = SUB_IDLE;
      default:                  state_nxt = SUB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SUB_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= 1'b1;
        idx_q   <= '0;
      end else if (state_q == SUB_BUSY) begin
        y_q     <= y_nxt;
        carry_q <= chunk_cout;
        if (last_chunk) begin
          // idx parks at NCHUNK-1 through DONE and wraps on consume.
          borrow_q <= ~chunk_cout;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else if (consume) begin
        idx_q <= '0;
      end
    end
  end

  assign y      = y_q;
  assign borrow = borrow_q;

`ifdef SUB_FLAGS_EN
  logic zf_q;
  logic sf_q;
  logic of_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if ((state_q == SUB_BUSY) && last_chunk) begin
      zf_q <= (y_nxt == '0);
      sf_q <= y_nxt[DATA_W-1];
      // Signed overflow: operands of differing sign and result sign != A sign.
      of_q <= (a_q[DATA_W-1] != b_q[DATA_W-1]) & (y_nxt[DATA_W-1] != a_q[DATA_W-1]);
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - self-checking bench for seq_subtractor
module tb_seq_subtractor;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [63:0] a_in      [NDUT];
  logic [63:0] b_in      [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [63:0] y         [NDUT];
  logic        borrow    [NDUT];
`ifdef SUB_FLAGS_EN
  logic        zf        [NDUT];
  logic        sf        [NDUT];
  logic        of        [NDUT];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] y;
    logic        borrow;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
    logic        borrow;
  } vec_t;
  vec_t vecs[8];

  // DUT 0: CHUNK_W=8, DUT 1: CHUNK_W=64, DUT 2: CHUNK_W=1
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CW = (g == 0) ? 8 : ((g == 1) ? 64 : 1);
    seq_subtractor #(
      .CHUNK_W (CW)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a_in[g]),
      .b         (b_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .y         (y[g]),
`ifdef SUB_FLAGS_EN
      .zf        (zf[g]),
      .sf        (sf[g]),
      .of        (of[g]),
`endif
      .borrow    (borrow[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic int nchunk(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 1 : 64);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full operation: accept, measure latency, compare against the
  // scoreboard, optionally stall in DONE with in_valid held high, consume.
  task automatic run_op(input int d, input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] ey, input logic eb, input int hold);
    int   n;
    int   lat;
    exp_t e;
    @(negedge clk);
    a_in[d] = av;
    b_in[d] = bv;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    sb.push_back('{y: ey, borrow: eb});
    lat = 0;
    forever begin
      @(negedge clk);
      if (hold == 0) in_valid[d] = 1'b0;
      else begin
        a_in[d] = {$urandom, $urandom};
        b_in[d] = {$urandom, $urandom};
      end
      if (out_valid[d] || lat >= 200) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(nchunk(d)));
    e = sb.pop_front();
    chk("y", y[d], e.y);
    chk("borrow", 64'(borrow[d]), 64'(e.borrow));
`ifdef SUB_FLAGS_EN
    chk("zf", 64'(zf[d]), 64'(e.y == 64'd0));
    chk("sf", 64'(sf[d]), 64'(e.y[63]));
    chk("of", 64'(of[d]), 64'((av[63] != bv[63]) && (e.y[63] != av[63])));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a_in[d] = {$urandom, $urandom};
      chk("hold_y_stable", y[d], e.y);
      chk("hold_out_valid", 64'(out_valid[d]), 64'd1);
      chk("hold_in_ready", 64'(in_ready[d]), 64'd0);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    chk("consume_out_valid", 64'(out_valid[d]), 64'd0);
    chk("consume_in_ready", 64'(in_ready[d]), 64'd1);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;

    vecs[0] = '{a: 64'd5, b: 64'd3, y: 64'd2, borrow: 1'b0};
    vecs[1] = '{a: 64'd0, b: 64'd1, y: 64'hFFFF_FFFF_FFFF_FFFF, borrow: 1'b1};
    vecs[2] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, y: 64'h7FFF_FFFF_FFFF_FFFF, borrow: 1'b0};
    vecs[3] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, y: 64'd0, borrow: 1'b0};
    vecs[4] = '{a: 64'd0, b: 64'd0, y: 64'd0, borrow: 1'b0};
    vecs[5] = '{a: 64'd1, b: 64'hFFFF_FFFF_FFFF_FFFF, y: 64'd2, borrow: 1'b1};
    vecs[6] = '{a: 64'h100, b: 64'h1, y: 64'hFF, borrow: 1'b0};
    vecs[7] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'h0000_0001_0000_0001,
                y: 64'h0123_4566_89AB_CDEE, borrow: 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      a_in[d]      = 64'd0;
      b_in[d]      = 64'd0;
    end
    repeat (3) @(negedge clk);

    for (int d = 0; d < NDUT; d++) begin
      chk("reset_in_ready", 64'(in_ready[d]), 64'd1);
      chk("reset_out_valid", 64'(out_valid[d]), 64'd0);
      chk("reset_y", y[d], 64'd0);
      chk("reset_borrow", 64'(borrow[d]), 64'd0);
`ifdef SUB_FLAGS_EN
      chk("reset_zf", 64'(zf[d]), 64'd0);
`endif
    end
    rst_n = 1'b1;

    // Table vectors on every chunk width
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 8; i++)
        run_op(d, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].borrow, 0);

    // Stall in DONE for 10 cycles with in_valid held high
    run_op(0, 64'd1000, 64'd1, 64'd999, 1'b0, 10);

    // Reset during BUSY at chunk 3 aborts the operation
    @(negedge clk);
    a_in[0] = 64'hDEAD_BEEF_CAFE_F00D;
    b_in[0] = 64'h0000_0000_0000_000D;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
    chk("abort_out_valid", 64'(out_valid[0]), 64'd0);
    chk("abort_y", y[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (out_valid[0]) seen++;
      end
      chk("abort_no_output", 64'(seen), 64'd0);
    end
    run_op(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 0);

    // Random operands on the widest and narrowest chunk builds
    for (int d = 1; d < NDUT; d++) begin
      for (int i = 0; i < 200; i++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (i % 17 == 0) rb = ra;
        if (i % 13 == 0) rb = ra + 64'd1;
        run_op(d, ra, rb, ra - rb, (ra < rb), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
